bit_destuffing: RTL and testbench

BIT_DESTUFFING -- requirements
Module: bit_destuffing

---
 rtl/bit_destuffing.sv | 122 ++++++++++++
 tb/tb_bit_destuffing.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bit_destuffing.sv
// Receive-side bit destuffer: removes the stuff bit inserted after RUN_LEN equal
// bits inside the stuffed region and flags runs that break the stuffing rule.
module bit_destuffing #(
    parameter int RUN_LEN = 5,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             frame_start,
    input  logic             stuff_en,
    input  logic             err_clear,
    output logic             data_out,
    output logic             data_out_valid,
    output logic             stuff_removed,
    output logic             stuff_error,
    output logic             err_sticky,
    output logic [CNT_W-1:0] bit_count
);

    // Input handshake: one bit is accepted on every rising edge with data_valid=1;
    // there is no backpressure. Outputs appear one cycle later and pulse for one cycle.

    typedef enum logic [1:0] {IDLE, RUN, ERROR} state_e;

    localparam logic [2:0] RUN_LEN_C = 3'(RUN_LEN);

    state_e           state_q, state_d;
    logic [2:0]       run_cnt_q, run_cnt_d;
    logic             last_bit_q, last_bit_d;
    logic             data_out_q, data_out_d;
    logic             dv_q, dv_d;
    logic             sr_q, sr_d;
    logic             se_q, se_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] bc_q, bc_d;
    logic             emit;

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        last_bit_d = last_bit_q;
        data_out_d = data_out_q;
        dv_d       = 1'b0;
        sr_d       = 1'b0;
        se_d       = 1'b0;
        sticky_d   = err_clear ? 1'b0 : sticky_q;
        bc_d       = bc_q;
        emit       = 1'b0;

        if (data_valid) begin
            if (frame_start) begin
                // SOF restarts the frame from any state, including ERROR
                state_d    = RUN;
                run_cnt_d  = 3'd1;
                last_bit_d = data_in;
                emit       = 1'b1;
            end else if (state_q == RUN) begin
                if (!stuff_en) begin
                    run_cnt_d  = 3'd0;
                    last_bit_d = data_in;
                    emit       = 1'b1;
                end else if (run_cnt_q < RUN_LEN_C) begin
                    run_cnt_d  = (data_in == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
                    last_bit_d = data_in;
                    emit       = 1'b1;
                end else if (data_in != last_bit_q) begin
                    sr_d       = 1'b1;
                    run_cnt_d  = 3'd1;
                    last_bit_d = data_in;
                end else begin
                    se_d     = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = ERROR;
                end
            end
        end

        if (emit) begin
            dv_d       = 1'b1;
            data_out_d = data_in;
            if (frame_start) begin
                bc_d = CNT_W'(1);
            end else if (bc_q != {CNT_W{1'b1}}) begin
                bc_d = bc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            run_cnt_q  <= 3'd0;
            last_bit_q <= 1'b1;
            data_out_q <= 1'b0;
            dv_q       <= 1'b0;
            sr_q       <= 1'b0;
            se_q       <= 1'b0;
            sticky_q   <= 1'b0;
            bc_q       <= '0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            last_bit_q <= last_bit_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
            sr_q       <= sr_d;
            se_q       <= se_d;
            sticky_q   <= sticky_d;
            bc_q       <= bc_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = dv_q;
    assign stuff_removed  = sr_q;
    assign stuff_error    = se_q;
    assign err_sticky     = sticky_q;
    assign bit_count      = bc_q;

endmodule

// File: tb/tb_bit_destuffing.sv
// Directed self-checking bench for bit_destuffing with hand-computed expectations.
module tb_bit_destuffing;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             data_in = 1'b0;
    logic             data_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             stuff_en = 1'b1;
    logic             err_clear = 1'b0;
    logic             data_out;
    logic             data_out_valid;
    logic             stuff_removed;
    logic             stuff_error;
    logic             err_sticky;
    logic [CNT_W-1:0] bit_count;

    int checks = 0;
    int errors = 0;

    bit_destuffing #(.RUN_LEN(5), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .frame_start    (frame_start),
        .stuff_en       (stuff_en),
        .err_clear      (err_clear),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .stuff_removed  (stuff_removed),
        .stuff_error    (stuff_error),
        .err_sticky     (err_sticky),
        .bit_count      (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one bit, then check the registered result one cycle later.
    task automatic step(input logic fs, input logic d, input logic se,
                        input logic ev, input logic eo, input logic esr, input logic ese,
                        input string tag);
        frame_start = fs;
        data_in     = d;
        stuff_en    = se;
        data_valid  = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(data_out_valid), 32'(ev));
        check({tag, ".dout"},  32'(data_out),       32'(eo));
        check({tag, ".srm"},   32'(stuff_removed),  32'(esr));
        check({tag, ".serr"},  32'(stuff_error),    32'(ese));
        data_valid  = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".dout"},   32'(data_out),       32'd0);
        check({tag, ".valid"},  32'(data_out_valid), 32'd0);
        check({tag, ".srm"},    32'(stuff_removed),  32'd0);
        check({tag, ".serr"},   32'(stuff_error),    32'd0);
        check({tag, ".sticky"}, 32'(err_sticky),     32'd0);
        check({tag, ".count"},  32'(bit_count),      32'd0);
    endtask

    initial begin
        // reset
        #2;
        check_reset_values("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // IDLE ignores bits without SOF
        step(0, 1, 1, 0, 0, 0, 0, "idle_ign");
        check("idle_ign.count", 32'(bit_count), 32'd0);

        // 0 (SOF),0,0,0,0 then stuff 1 removed, then 0
        step(1, 0, 1, 1, 0, 0, 0, "stuff0_sof");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0, 0, "stuff0_run");
        step(0, 1, 1, 0, 0, 1, 0, "stuff0_rm");
        step(0, 0, 1, 1, 0, 0, 0, "stuff0_after");
        check("stuff0.count", 32'(bit_count), 32'd6);
        check("stuff0.sticky", 32'(err_sticky), 32'd0);

        // alternating 20 bits
        for (int i = 0; i < 20; i++) begin
            logic b;
            b = i[0];
            step(i == 0, b, 1, 1, b, 0, 0, "alt");
        end
        check("alt.count", 32'(bit_count), 32'd20);

        // six 1s -> stuff error, then ERROR ignores bits
        step(1, 1, 1, 1, 1, 0, 0, "err_sof");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 0, 0, "err_run");
        step(0, 1, 1, 0, 1, 0, 1, "err_six");
        check("err.sticky", 32'(err_sticky), 32'd1);
        check("err.count", 32'(bit_count), 32'd5);
        step(0, 0, 1, 0, 1, 0, 0, "err_ign0");
        step(0, 1, 0, 0, 1, 0, 0, "err_ign1");
        check("err_ign.count", 32'(bit_count), 32'd5);
        check("err_ign.sticky", 32'(err_sticky), 32'd1);

        // err_clear together with SOF while in ERROR
        err_clear = 1'b1;
        step(1, 0, 1, 1, 0, 0, 0, "clr_sof");
        err_clear = 1'b0;
        check("clr_sof.sticky", 32'(err_sticky), 32'd0);
        check("clr_sof.count", 32'(bit_count), 32'd1);
        step(0, 1, 1, 1, 1, 0, 0, "clr_next");
        check("clr_next.count", 32'(bit_count), 32'd2);

        // stuff error coinciding with err_clear keeps sticky set
        step(1, 1, 1, 1, 1, 0, 0, "coin_sof");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 1, 0, 0, "coin_run");
        err_clear = 1'b1;
        step(0, 1, 1, 0, 1, 0, 1, "coin_err");
        check("coin.sticky", 32'(err_sticky), 32'd1);
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("coin_clr.sticky", 32'(err_sticky), 32'd0);
        check("idle_cycle.valid", 32'(data_out_valid), 32'd0);

        // pass-through region then stuffing enabled
        step(1, 1, 0, 1, 1, 0, 0, "pass_sof");
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 1, 0, 0, "pass_run");
        check("pass.count", 32'(bit_count), 32'd8);
        check("pass.sticky", 32'(err_sticky), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 1, 0, 0, "en_run");
        step(0, 1, 1, 0, 1, 0, 1, "en_six");
        check("en.count", 32'(bit_count), 32'd13);
        check("en.sticky", 32'(err_sticky), 32'd1);

        // bit_count saturates at 255
        err_clear = 1'b1;
        for (int i = 0; i < 260; i++) begin
            logic b;
            b = i[0];
            step(i == 0, b, 0, 1, b, 0, 0, "sat");
            if (i == 254) check("sat.count254", 32'(bit_count), 32'd255);
        end
        err_clear = 1'b0;
        check("sat.count", 32'(bit_count), 32'd255);

        // reset mid-frame
        step(1, 1, 1, 1, 1, 0, 0, "mid_sof");
        step(0, 0, 1, 1, 0, 0, 0, "mid_b2");
        step(0, 1, 1, 1, 1, 0, 0, "mid_b3");
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 1, 0, 0, 0, 0, "post_rst1");
        step(0, 0, 1, 0, 0, 0, 0, "post_rst2");
        check("post_rst.count", 32'(bit_count), 32'd0);
        step(1, 1, 1, 1, 1, 0, 0, "post_rst_sof");
        check("post_rst_sof.count", 32'(bit_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
